// File: rtl/mdu_issue_arb_if.sv
// mdu_issue_arb_if: requester-side and MDU-side signal bundle for the MDU issue arbiter.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge where
// the valid signal (in_req[i] / mdu_req) and its ready (in_rdy[i] / mdu_rdy) are both
// high. A source holds valid and its payload stable until that edge. Ready may depend
// combinationally on valid; valid never depends on ready.
interface mdu_issue_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    // requester side
    logic [NUM_REQ-1:0]       in_req;
    logic [NUM_REQ-1:0]       in_rdy;
    logic [NUM_REQ*3-1:0]     in_opc;
    logic [NUM_REQ*32-1:0]    in_src1;
    logic [NUM_REQ*32-1:0]    in_src2;
    logic [NUM_REQ*TAG_W-1:0] in_tag;

    // MDU side
    logic             mdu_req;
    logic             mdu_rdy;
    logic [2:0]       mdu_opc;
    logic [31:0]      mdu_src1;
    logic [31:0]      mdu_src2;
    logic [TAG_W-1:0] mdu_tag;

    // environment view: reservation stations and the MDU
    modport master (
        output in_req, in_opc, in_src1, in_src2, in_tag, mdu_rdy,
        input  in_rdy, mdu_req, mdu_opc, mdu_src1, mdu_src2, mdu_tag
    );

    // arbiter view
    modport slave (
        input  in_req, in_opc, in_src1, in_src2, in_tag, mdu_rdy,
        output in_rdy, mdu_req, mdu_opc, mdu_src1, mdu_src2, mdu_tag
    );
endinterface

// File: rtl/mdu_issue_arb.sv
// mdu_issue_arb: shares the single multiply/divide unit among NUM_REQ reservation-station
// requesters. One pending operation per cycle is picked round-robin and captured in a
// one-entry issue register that drives the MDU req/rdy port until accepted.
//
// Build option: define MDU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// the round-robin pointer is then removed and effectively reads 0.
module mdu_issue_arb #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    mdu_issue_arb_if.slave      bus,
    output logic [15:0]         issue_cnt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // issue register
    logic             r_valid;
    logic [2:0]       r_opc;
    logic [31:0]      r_src1;
    logic [31:0]      r_src2;
    logic [TAG_W-1:0] r_tag;
    logic [15:0]      r_cnt;

    // per-requester payload views
    logic [2:0]       w_opc_a  [NUM_REQ];
    logic [31:0]      w_src1_a [NUM_REQ];
    logic [31:0]      w_src2_a [NUM_REQ];
    logic [TAG_W-1:0] w_tag_a  [NUM_REQ];

    // arbitration results
    logic               w_load_ok;
    logic               w_found;
    logic               w_accept;
    logic               w_hs;
    logic [NUM_REQ-1:0] w_grant;
    logic [2:0]         w_opc;
    logic [31:0]        w_src1;
    logic [31:0]        w_src2;
    logic [TAG_W-1:0]   w_tag;

`ifndef MDU_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_opc_a[g]  = bus.in_opc[3*g +: 3];
        assign w_src1_a[g] = bus.in_src1[32*g +: 32];
        assign w_src2_a[g] = bus.in_src2[32*g +: 32];
        assign w_tag_a[g]  = bus.in_tag[TAG_W*g +: TAG_W];
    end

    // The slot can take a new entry when empty or when the MDU takes the current one
    // this cycle; reset and flush block loading.
    assign w_load_ok = !rst && !flush && (!r_valid || bus.mdu_rdy);
    assign w_accept  = w_load_ok && w_found;
    assign w_hs      = r_valid && bus.mdu_rdy;

    assign bus.in_rdy   = w_load_ok ? w_grant : '0;
    assign bus.mdu_req  = r_valid;
    assign bus.mdu_opc  = r_opc;
    assign bus.mdu_src1 = r_src1;
    assign bus.mdu_src2 = r_src2;
    assign bus.mdu_tag  = r_tag;
    assign issue_cnt    = r_cnt;

    // Priority search starting at the pointer (or at 0 in fixed mode); first hit wins.
    always_comb begin : p_grant
        logic [PTR_W-1:0] v_idx;
        w_grant = '0;
        w_found = 1'b0;
        w_opc   = '0;
        w_src1  = '0;
        w_src2  = '0;
        w_tag   = '0;
        v_idx   = '0;
`ifndef MDU_ARB_FIXED_PRIO_EN
        w_ptr_nxt = r_ptr;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MDU_ARB_FIXED_PRIO_EN
            v_idx = PTR_W'(k);
`else
            v_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
`endif
            if (!w_found && bus.in_req[v_idx]) begin
                w_found        = 1'b1;
                w_grant[v_idx] = 1'b1;
                w_opc          = w_opc_a[v_idx];
                w_src1         = w_src1_a[v_idx];
                w_src2         = w_src2_a[v_idx];
                w_tag          = w_tag_a[v_idx];
`ifndef MDU_ARB_FIXED_PRIO_EN
                w_ptr_nxt      = PTR_W'((int'(v_idx) + 1) % NUM_REQ);
`endif
            end
        end
    end

    // Issue register and counter: flush drops the entry, a coincident MDU accept still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_opc   <= '0;
            r_src1  <= '0;
            r_src2  <= '0;
            r_tag   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_hs) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_opc   <= w_opc;
                r_src1  <= w_src1;
                r_src2  <= w_src2;
                r_tag   <= w_tag;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifndef MDU_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves just past the winner on each accept; holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_mdu_issue_arb.sv
// tb_mdu_issue_arb: bench for mdu_issue_arb (round-robin build). A reference model runs
// on the falling edge, predicts in_rdy/mdu_req/issue_cnt and keeps a queue of expected
// issue-register contents; directed sequences cover the reset, arbitration, backpressure,
// flush and counter-wrap cases.
module tb_mdu_issue_arb;
    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 4;
    localparam int PW      = 3 + 32 + 32 + TAG_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] issue_cnt;

    mdu_issue_arb_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

    mdu_issue_arb #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .issue_cnt (issue_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    logic [1:0]    grant_log[$];
    bit            mon_en = 1'b0;
    bit            log_en = 1'b0;
    bit            m_valid = 1'b0;
    int            m_ptr = 0;
    logic [15:0]   m_cnt = '0;
    logic [1:0]    acc_q = '0;
    bit            m_load_ok;
    bit            m_found;
    int            m_win;
    logic [1:0]    m_exp_rdy;

    function automatic logic [PW-1:0] pay(input int w);
        return {bus.in_opc[3*w +: 3], bus.in_src1[32*w +: 32],
                bus.in_src2[32*w +: 32], bus.in_tag[TAG_W*w +: TAG_W]};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            m_load_ok = !rst && !flush && (!m_valid || bus.mdu_rdy);
            m_found   = 1'b0;
            m_win     = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!m_found && bus.in_req[(m_ptr + k) % NUM_REQ]) begin
                    m_found = 1'b1;
                    m_win   = (m_ptr + k) % NUM_REQ;
                end
            end
            m_exp_rdy = '0;
            if (m_load_ok && m_found) m_exp_rdy[m_win] = 1'b1;

            check_eq("in_rdy", 128'(bus.in_rdy), 128'(m_exp_rdy));
            check_eq("mdu_req", 128'(bus.mdu_req), 128'(m_valid));
            if (m_valid) begin
                if (exp_q.size() == 0)
                    check_eq("sb_underflow", 128'(0), 128'(1));
                else
                    check_eq("mdu_payload",
                             128'({bus.mdu_opc, bus.mdu_src1, bus.mdu_src2, bus.mdu_tag}),
                             128'(exp_q[0]));
            end
            check_eq("issue_cnt", 128'(issue_cnt), 128'(m_cnt));

            acc_q = bus.in_req & bus.in_rdy;
            if (log_en) grant_log.push_back(bus.in_rdy);

            // advance model across the coming rising edge
            if (rst) begin
                m_valid = 1'b0;
                m_ptr   = 0;
                m_cnt   = '0;
                exp_q.delete();
            end else begin
                if (m_valid && (bus.mdu_rdy || flush) && exp_q.size() > 0)
                    void'(exp_q.pop_front());
                if (m_valid && bus.mdu_rdy) m_cnt = m_cnt + 16'd1;
                if (flush) begin
                    m_valid = 1'b0;
                end else if (m_load_ok && m_found) begin
                    exp_q.push_back(pay(m_win));
                    m_valid = 1'b1;
                    m_ptr   = (m_win + 1) % NUM_REQ;
                end else if (m_valid && bus.mdu_rdy) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [2:0] opc, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [TAG_W-1:0] tag);
        bus.in_opc[3*p +: 3]          = opc;
        bus.in_src1[32*p +: 32]       = s1;
        bus.in_src2[32*p +: 32]       = s2;
        bus.in_tag[TAG_W*p +: TAG_W]  = tag;
    endtask

    task automatic rand_port(input int p);
        set_port(p, 3'($urandom_range(7)), $urandom, $urandom, TAG_W'($urandom_range(15)));
    endtask

    // new payload only for requesters accepted at the last edge
    task automatic refresh_accepted();
        for (int p = 0; p < NUM_REQ; p++)
            if (acc_q[p]) rand_port(p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        check_eq("watchdog", 128'(0), 128'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [1:0]  rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] cnt_snap;
    int          n;

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        bus.in_req  = '0;
        bus.mdu_rdy = 1'b0;
        bus.in_opc  = '0;
        bus.in_src1 = '0;
        bus.in_src2 = '0;
        bus.in_tag  = '0;
        tick();
        mon_en = 1'b1;

        // reset state; requests are ignored while rst is high
        bus.in_req = 2'b11;
        #1;
        check_eq("rst_in_rdy", 128'(bus.in_rdy), 128'(2'b00));
        tick();
        check_eq("rst_mdu_req", 128'(bus.mdu_req), 128'(0));
        check_eq("rst_payload", 128'({bus.mdu_opc, bus.mdu_src1, bus.mdu_src2, bus.mdu_tag}), 128'(0));
        check_eq("rst_cnt", 128'(issue_cnt), 128'(0));
        rst        = 1'b0;
        bus.in_req = '0;

        // single requester
        set_port(0, 3'd0, 32'd7, 32'd6, 4'd3);
        bus.in_req = 2'b01;
        #1;
        check_eq("t1_in_rdy", 128'(bus.in_rdy), 128'(2'b01));
        tick();
        bus.in_req  = '0;
        bus.mdu_rdy = 1'b1;
        #1;
        check_eq("t1_mdu_req", 128'(bus.mdu_req), 128'(1));
        check_eq("t1_src1", 128'(bus.mdu_src1), 128'(7));
        check_eq("t1_src2", 128'(bus.mdu_src2), 128'(6));
        check_eq("t1_tag", 128'(bus.mdu_tag), 128'(3));
        tick();
        bus.mdu_rdy = 1'b0;
        #1;
        check_eq("t1_req_drop", 128'(bus.mdu_req), 128'(0));
        check_eq("t1_cnt", 128'(issue_cnt), 128'(1));

        // round robin with both ports held and the MDU always ready
        do_reset();
        rand_port(0);
        rand_port(1);
        bus.in_req  = 2'b11;
        bus.mdu_rdy = 1'b1;
        log_en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            refresh_accepted();
        end
        log_en     = 1'b0;
        bus.in_req = '0;
        tick();
        bus.mdu_rdy = 1'b0;
        check_eq("rr_len", 128'(grant_log.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size())
                check_eq("rr_grant", 128'(grant_log[i]), 128'(rr_exp[i]));

        // backpressure: slot full, MDU stalls 5 cycles, then same-cycle refill
        set_port(0, 3'd4, 32'd100, 32'd200, 4'd5);
        bus.in_req = 2'b01;
        tick();
        set_port(1, 3'd5, 32'd300, 32'd400, 4'd6);
        bus.in_req = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_in_rdy", 128'(bus.in_rdy), 128'(2'b00));
            check_eq("bp_hold_tag", 128'(bus.mdu_tag), 128'(5));
            check_eq("bp_hold_src1", 128'(bus.mdu_src1), 128'(100));
            tick();
        end
        bus.mdu_rdy = 1'b1;
        #1;
        check_eq("bp_refill_rdy", 128'(bus.in_rdy), 128'(2'b10));
        tick();
        bus.mdu_rdy = 1'b0;
        bus.in_req  = '0;
        #1;
        check_eq("bp_req_stays", 128'(bus.mdu_req), 128'(1));
        check_eq("bp_new_tag", 128'(bus.mdu_tag), 128'(6));
        check_eq("bp_new_src1", 128'(bus.mdu_src1), 128'(300));

        // flush with slot full and MDU stalled
        cnt_snap   = m_cnt;
        flush      = 1'b1;
        bus.in_req = 2'b11;
        #1;
        check_eq("fl_in_rdy", 128'(bus.in_rdy), 128'(2'b00));
        tick();
        flush = 1'b0;
        #1;
        check_eq("fl_mdu_req", 128'(bus.mdu_req), 128'(0));
        check_eq("fl_cnt", 128'(issue_cnt), 128'(cnt_snap));
        check_eq("fl_ptr_grant", 128'(bus.in_rdy), 128'(2'b01));
        tick();
        bus.in_req  = '0;
        bus.mdu_rdy = 1'b1;
        tick();
        bus.mdu_rdy = 1'b0;

        // long stream up to issue_cnt = 0xFFFF, then one more handshake wraps it
        rand_port(0);
        rand_port(1);
        bus.in_req  = 2'b11;
        bus.mdu_rdy = 1'b1;
        n = 0;
        while (m_cnt != 16'hFFFF && n < 70000) begin
            tick();
            refresh_accepted();
            n++;
        end
        check_eq("stream_bound", 128'(n < 70000), 128'(1));
        bus.in_req = '0;
        #1;
        check_eq("cnt_max", 128'(issue_cnt), 128'(16'hFFFF));
        check_eq("cnt_max_req", 128'(bus.mdu_req), 128'(1));
        tick();
        bus.mdu_rdy = 1'b0;
        #1;
        check_eq("cnt_wrap", 128'(issue_cnt), 128'(16'h0000));
        check_eq("cnt_wrap_req", 128'(bus.mdu_req), 128'(0));

        // reset mid-operation: slot full, ptr=1, counter nonzero
        set_port(0, 3'd1, 32'd11, 32'd12, 4'd9);
        bus.in_req = 2'b01;
        tick();
        set_port(1, 3'd2, 32'd21, 32'd22, 4'd10);
        bus.in_req  = 2'b10;
        bus.mdu_rdy = 1'b1;
        tick();
        set_port(0, 3'd3, 32'd31, 32'd32, 4'd11);
        bus.in_req = 2'b01;
        tick();
        bus.mdu_rdy = 1'b0;
        bus.in_req  = 2'b11;
        #1;
        check_eq("r5_pre_cnt", 128'(issue_cnt), 128'(2));
        check_eq("r5_pre_ptr_grant", 128'(bus.in_rdy), 128'(2'b00));
        rst = 1'b1;
        #1;
        check_eq("r5_rst_in_rdy", 128'(bus.in_rdy), 128'(2'b00));
        tick();
        rst = 1'b0;
        #1;
        check_eq("r5_mdu_req", 128'(bus.mdu_req), 128'(0));
        check_eq("r5_payload", 128'({bus.mdu_opc, bus.mdu_src1, bus.mdu_src2, bus.mdu_tag}), 128'(0));
        check_eq("r5_cnt", 128'(issue_cnt), 128'(0));
        check_eq("r5_grant", 128'(bus.in_rdy), 128'(2'b01));
        tick();
        bus.in_req  = '0;
        bus.mdu_rdy = 1'b1;
        #1;
        check_eq("r5_issue_tag", 128'(bus.mdu_tag), 128'(11));
        tick();
        bus.mdu_rdy = 1'b0;
        tick();
        check_eq("sb_drained", 128'(exp_q.size()), 128'(0));

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
